err_compute: RTL and testbench

//  Upstream error stage of the line-follower PID. Captures a frame of eight 12-bit IR sensor

---
 rtl/err_compute.sv | 185 ++++++++++++++++++
 tb/tb_err_compute.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/err_compute.sv
// ---------------------------------------------------------------------------
// err_compute
//   Upstream error stage of the line-follower PID. A frame of eight 12-bit IR
//   readings is captured on ir_vld, then walked one sensor per cycle to build
//   a signed, position-weighted sum. The sum is arithmetically scaled down and
//   saturated to an 11-bit signed error.
//
//   Sensor weights, outer-left to outer-right: -8 -4 -2 -1 +1 +2 +4 +8.
//   A positive error means the line lies to the right.
//
// Parameters
//   SHIFT   arithmetic right shift applied to the weighted sum before clamping
//   THRESH  sensor level at or above which a sensor is counted as on the line
//
// Ports
//   clk           system clock; all state changes on its rising edge
//   rst           synchronous, active-high reset
//   ir_vld        one-cycle pulse: ir_data holds a new frame
//   ir_data       sensor i occupies bits [12*i+11:12*i]
//   err_sat       signed saturated error, -1024..+1023 (held between pulses)
//   err_vld       one-cycle pulse: err_sat / line_present were just updated
//   line_present  some sensor of the last frame reached THRESH
//   busy          a frame is in flight (combinational from the FSM state)
//   overrun       sticky: a frame arrived while busy; cleared only by rst
//
// Build option
//   ERR_FILT_EN   when defined, err_sat is a 2-tap average of the previous
//                 output and the new saturated value; latency is unchanged.
// ---------------------------------------------------------------------------
module err_compute #(
    parameter int          SHIFT  = 4,
    parameter logic [11:0] THRESH = 12'd512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_vld,
    input  logic [95:0] ir_data,
    output logic [10:0] err_sat,
    output logic        err_vld,
    output logic        line_present,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } state_t;

    state_t              state_reg;
    logic signed [16:0]  acc_reg;
    logic [2:0]          idx_reg;
    logic [11:0]         frame_reg [8];
    logic                line_reg;

    logic [10:0]         err_sat_reg;
    logic                err_vld_reg;
    logic                line_present_reg;
    logic                overrun_reg;

    // Per-sensor views of the incoming word and of the "on line" test.
    logic [11:0]         sensor_in [8];
    logic [7:0]          sensor_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sensor
            assign sensor_in[gi]  = ir_data[12*gi +: 12];
            assign sensor_hit[gi] = (frame_reg[gi] >= THRESH);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Weighted accumulate: |w| = 2^shamt, sign negative for the left half.
    // Left side idx 0..3 maps to shifts 3..0, right side idx 4..7 to 0..3,
    // so the shift amount is idx[1:0] on the right and its inverse on the left.
    // -----------------------------------------------------------------------
    logic [1:0]          shamt;
    logic signed [16:0]  mag;
    logic signed [16:0]  acc_next;

    always_comb begin
        shamt    = idx_reg[2] ? idx_reg[1:0] : ~idx_reg[1:0];
        mag      = $signed({5'd0, frame_reg[idx_reg]} << shamt);
        acc_next = idx_reg[2] ? (acc_reg + mag) : (acc_reg - mag);
    end

    // -----------------------------------------------------------------------
    // Scale and clamp. >>> on a signed value rounds toward minus infinity.
    // -----------------------------------------------------------------------
    logic signed [16:0]  scaled;
    logic [10:0]         sat_new;
    logic [10:0]         err_next;

    always_comb begin
        scaled = acc_reg >>> SHIFT;
        if (scaled > 17'sd1023) begin
            sat_new = 11'h3FF;
        end else if (scaled < -17'sd1024) begin
            sat_new = 11'h400;
        end else begin
            sat_new = scaled[10:0];
        end
    end

`ifdef ERR_FILT_EN
    // Average with the previously published value; 12 bits hold the sum of
    // two 11-bit signed numbers, and the halving cannot leave 11-bit range.
    logic signed [11:0]  filt_sum;

    always_comb begin
        filt_sum = $signed({err_sat_reg[10], err_sat_reg}) + $signed({sat_new[10], sat_new});
        err_next = 11'(filt_sum >>> 1);
    end
`else
    always_comb begin
        err_next = sat_new;
    end
`endif

    // -----------------------------------------------------------------------
    // Control FSM and all registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            idx_reg          <= '0;
            line_reg         <= 1'b0;
            err_sat_reg      <= '0;
            err_vld_reg      <= 1'b0;
            line_present_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                frame_reg[i] <= '0;
            end
        end else begin
            err_vld_reg <= 1'b0;

            // A frame offered while one is in flight is dropped but remembered.
            if (ir_vld && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (ir_vld) begin
                        for (int i = 0; i < 8; i++) begin
                            frame_reg[i] <= sensor_in[i];
                        end
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        line_reg  <= 1'b0;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_reg  <= acc_next;
                    line_reg <= line_reg | sensor_hit[idx_reg];
                    idx_reg  <= idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_reg <= SAT;
                    end
                end
                SAT: begin
                    err_sat_reg      <= err_next;
                    line_present_reg <= line_reg;
                    err_vld_reg      <= 1'b1;
                    state_reg        <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_reg != IDLE);
    assign err_sat      = err_sat_reg;
    assign err_vld      = err_vld_reg;
    assign line_present = line_present_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_err_compute.sv
// ---------------------------------------------------------------------------
// tb_err_compute
//   Self-checking bench for err_compute (default build). Directed frames cover
//   zero input, both saturation limits, small values and the line threshold;
//   randomized frames with random gaps (including back-to-back acceptance)
//   are checked against an arithmetic reference model. Overrun and mid-frame
//   reset behaviour are exercised at the end.
// ---------------------------------------------------------------------------
module tb_err_compute;

    logic        clk;
    logic        rst;
    logic        ir_vld;
    logic [95:0] ir_data;
    logic [10:0] err_sat;
    logic        err_vld;
    logic        line_present;
    logic        busy;
    logic        overrun;

    int checks_cnt;
    int errors_cnt;

    logic [11:0] sens [8];

    err_compute dut (
        .clk          (clk),
        .rst          (rst),
        .ir_vld       (ir_vld),
        .ir_data      (ir_data),
        .err_sat      (err_sat),
        .err_vld      (err_vld),
        .line_present (line_present),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: weighted sum, floor division by 16, clamp to 11-bit signed.
    function automatic int model_err();
        int w [8] = '{-8, -4, -2, -1, 1, 2, 4, 8};
        int sum = 0;
        int q;
        for (int i = 0; i < 8; i++) sum += w[i] * int'(sens[i]);
        if (sum >= 0) q = sum / 16;
        else          q = -((-sum + 15) / 16);
        if (q > 1023)  q = 1023;
        if (q < -1024) q = -1024;
        return q;
    endfunction

    function automatic int model_line();
        for (int i = 0; i < 8; i++) if (sens[i] >= 12'd512) return 1;
        return 0;
    endfunction

    function automatic logic [95:0] pack_sens();
        logic [95:0] v;
        for (int i = 0; i < 8; i++) v[12*i +: 12] = sens[i];
        return v;
    endfunction

    task automatic clear_sens();
        for (int i = 0; i < 8; i++) sens[i] = 12'd0;
    endtask

    // Offer the frame in sens[], wait (bounded) for err_vld and check it.
    // Returns #1 after the edge that raised err_vld.
    task automatic run_frame(input string tag);
        int found;
        int exp_err;
        int exp_line;
        exp_err  = model_err();
        exp_line = model_line();
        ir_data  = pack_sens();
        ir_vld   = 1'b1;
        @(posedge clk);
        #1;
        ir_vld = 1'b0;
        check_val({tag, "_busy"}, int'(busy), 1);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (err_vld) begin
                found = k;
                break;
            end
        end
        check_val({tag, "_latency"}, found, 9);
        check_val({tag, "_err_sat"}, int'($signed(err_sat)), exp_err);
        check_val({tag, "_line"}, int'(line_present), exp_line);
        check_val({tag, "_idle"}, int'(busy), 0);
        $display("frame %s: err_sat=%0d line=%0b expected %0d/%0d",
                 tag, $signed(err_sat), line_present, exp_err, exp_line);
    endtask

    initial begin
        int gap;
        int pulses;
        int held;
        checks_cnt = 0;
        errors_cnt = 0;
        rst     = 1'b1;
        ir_vld  = 1'b0;
        ir_data = '0;
        clear_sens();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_err_sat", int'(err_sat), 0);
        check_val("rst_err_vld", int'(err_vld), 0);
        check_val("rst_line", int'(line_present), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;

        // Directed frames
        clear_sens();
        run_frame("zero");
        check_val("zero_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        check_val("zero_vld_pulse", int'(err_vld), 0);

        clear_sens(); sens[7] = 12'd4095;
        run_frame("pos_clamp");
        check_val("pos_clamp_raw", int'(err_sat), 11'h3FF);
        @(posedge clk); #1;

        clear_sens(); sens[0] = 12'd4095;
        run_frame("neg_clamp");
        check_val("neg_clamp_raw", int'(err_sat), 11'h400);
        @(posedge clk); #1;

        clear_sens(); sens[3] = 12'd8;
        run_frame("minus_one");
        check_val("minus_one_raw", int'(err_sat), 11'h7FF);
        @(posedge clk); #1;

        clear_sens(); sens[4] = 12'd160;
        run_frame("plus_ten");
        check_val("plus_ten_val", int'($signed(err_sat)), 10);
        @(posedge clk); #1;

        clear_sens(); sens[2] = 12'd511;
        run_frame("below_thresh");
        @(posedge clk); #1;
        clear_sens(); sens[5] = 12'd512;
        run_frame("at_thresh");

        // Hold between pulses
        held = int'($signed(err_sat));
        repeat (4) @(posedge clk);
        #1;
        check_val("hold_err_sat", int'($signed(err_sat)), held);
        check_val("hold_line", int'(line_present), 1);

        // Randomized frames with random gaps (gap 0 = back-to-back acceptance)
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0:       sens[i] = 12'd0;
                    1:       sens[i] = 12'($urandom_range(0, 600));
                    default: sens[i] = 12'($urandom_range(0, 4095));
                endcase
            end
            run_frame($sformatf("rand%0d", n));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                check_val("rand_gap_vld", int'(err_vld), 0);
            end
        end
        check_val("rand_overrun", int'(overrun), 0);
        @(posedge clk); #1;

        // Overrun: second frame offered 3 cycles after the first is dropped
        clear_sens(); sens[6] = 12'd1000;
        ir_data = pack_sens();
        ir_vld  = 1'b1;
        @(posedge clk); #1;
        ir_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ir_data = '1;
        ir_vld  = 1'b1;
        @(posedge clk); #1;
        ir_vld = 1'b0;
        check_val("ovr_flag", int'(overrun), 1);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            if (err_vld) begin
                pulses++;
                check_val("ovr_err_sat", int'($signed(err_sat)), model_err());
            end
            @(posedge clk); #1;
        end
        check_val("ovr_pulses", pulses, 1);
        $display("overrun: pulses=%0d overrun=%0b", pulses, overrun);

        clear_sens(); sens[1] = 12'd700;
        run_frame("after_ovr");
        check_val("after_ovr_sticky", int'(overrun), 1);
        @(posedge clk); #1;

        // Reset in the middle of ACCUM (idx=4): frame abandoned, no err_vld
        clear_sens(); sens[7] = 12'd300;
        ir_data = pack_sens();
        ir_vld  = 1'b1;
        @(posedge clk); #1;
        ir_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid_rst_err_sat", int'(err_sat), 0);
        check_val("mid_rst_line", int'(line_present), 0);
        check_val("mid_rst_vld", int'(err_vld), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_overrun", int'(overrun), 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (err_vld) pulses++;
        end
        check_val("mid_rst_no_vld", pulses, 0);
        $display("mid-frame reset: err_sat=%0d busy=%0b pulses=%0d", $signed(err_sat), busy, pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
